// File: rtl/jk_pkg.sv
// ----------------------------------------------------------------------------
// jk_pkg
// Shared types and constants for the JK flip-flop target driver.
//   jk_state_t     : driver FSM states
//   POLICY_HOLD    : don't-care bits resolved so untouched cells hold
//   POLICY_TOGGLE  : don't-care bits resolved toward toggling
//   RETRY_W        : retry counter width (MAX_RETRY up to 7)
//   WAIT_W         : check-latency down-counter width (CHECK_LAT up to 15)
// ----------------------------------------------------------------------------
package jk_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    APPLY = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    FAIL  = 3'd4
  } jk_state_t;

  localparam int POLICY_HOLD   = 0;
  localparam int POLICY_TOGGLE = 1;

  localparam int RETRY_W = 3;
  localparam int WAIT_W  = 4;

endpackage

// File: rtl/jk_excite.sv
// ----------------------------------------------------------------------------
// jk_excite
// Purely combinational per-bit JK excitation: given the present Q and the
// desired next Q, produce J/K so that one clock edge moves Q to target.
// Ports:
//   i_q      [WIDTH]  present Q of the bank
//   i_target [WIDTH]  desired Q
//   o_j      [WIDTH]  J excitation
//   o_k      [WIDTH]  K excitation
// ----------------------------------------------------------------------------
module jk_excite
  import jk_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int POLICY = POLICY_HOLD
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_target,
  output logic [WIDTH-1:0] o_j,
  output logic [WIDTH-1:0] o_k
);

  generate
    if (POLICY == POLICY_TOGGLE) begin : g_toggle
      // Don't-cares set to 1: a changing bit always sees J=K=1 (toggle).
      assign o_j = i_target | i_q;
      assign o_k = ~(i_q & i_target);
    end else begin : g_hold
      // Don't-cares set to 0: only bits that must change are excited.
      assign o_j = i_target & ~i_q;
      assign o_k = i_q & ~i_target;
    end
  endgenerate

endmodule

// File: rtl/jk_target_driver.sv
// ----------------------------------------------------------------------------
// jk_target_driver
// Accepts a target word on valid/ready, excites a WIDTH-bit JK bank for one
// clock, checks the fed-back Q after CHECK_LAT cycles and retries up to
// MAX_RETRY times before latching a sticky fail.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   target handshake (ready only in IDLE)
//   in_target [WIDTH]   desired Q
//   q_fb      [WIDTH]   Q outputs of the JK bank
//   j, k      [WIDTH]   registered excitation, non-zero only in APPLY
//   done                one-cycle pulse on successful compare
//   mismatch            one-cycle pulse per failed compare
//   err_bits  [WIDTH]   target ^ q_fb of the last compare
//   fail                sticky, retries exhausted
//   clr                 leaves FAIL
//
// state | meaning
// IDLE  | ready for a target; acceptance loads j/k
// APPLY | j/k on the bank for exactly one cycle
// WAIT  | j/k = 0, let q_fb settle for CHECK_LAT-1 cycles
// CHECK | compare q_fb with the latched target at the closing edge
// FAIL  | retries exhausted; wait for clr
// ----------------------------------------------------------------------------
module jk_target_driver
  import jk_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int CHECK_LAT = 1,
  parameter int POLICY    = POLICY_HOLD,
  parameter int MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_target,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             done,
  output logic             mismatch,
  output logic [WIDTH-1:0] err_bits,
  output logic             fail,
  input  logic             clr
);

  // WAIT is entered with this count and leaves when it reaches zero,
  // giving CHECK_LAT-1 cycles in WAIT.
  localparam int WAIT_LOAD = (CHECK_LAT > 1) ? CHECK_LAT - 2 : 0;

  jk_state_t          r_state;
  logic [WIDTH-1:0]   r_target;
  logic [WIDTH-1:0]   r_j;
  logic [WIDTH-1:0]   r_k;
  logic               r_done;
  logic               r_mismatch;
  logic [WIDTH-1:0]   r_err_bits;
  logic               r_fail;
  logic [RETRY_W-1:0] r_retry;
  logic [WAIT_W-1:0]  r_wait_cnt;

  logic [WIDTH-1:0]   w_exc_target;
  logic [WIDTH-1:0]   w_j;
  logic [WIDTH-1:0]   w_k;
  logic [WIDTH-1:0]   w_err;

  // In IDLE the incoming word is the target; on a retry it is the latched
  // one. q_fb is always live so toggle policy stays correct after a
  // partial update.
  assign w_exc_target = (r_state == IDLE) ? in_target : r_target;
  assign w_err        = r_target ^ q_fb;

  jk_excite #(
    .WIDTH  (WIDTH),
    .POLICY (POLICY)
  ) u_excite (
    .i_q      (q_fb),
    .i_target (w_exc_target),
    .o_j      (w_j),
    .o_k      (w_k)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_target   <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_done     <= 1'b0;
      r_mismatch <= 1'b0;
      r_err_bits <= '0;
      r_fail     <= 1'b0;
      r_retry    <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_done     <= 1'b0;
      r_mismatch <= 1'b0;

      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_target <= in_target;
            r_j      <= w_j;
            r_k      <= w_k;
            r_retry  <= '0;
            r_state  <= APPLY;
          end
        end

        APPLY: begin
          r_j <= '0;
          r_k <= '0;
          if (CHECK_LAT > 1) begin
            r_wait_cnt <= WAIT_W'(WAIT_LOAD);
            r_state    <= WAIT;
          end else begin
            r_state <= CHECK;
          end
        end

        WAIT: begin
          if (r_wait_cnt == '0) begin
            r_state <= CHECK;
          end else begin
            r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
          end
        end

        CHECK: begin
          r_err_bits <= w_err;
          if (w_err == '0) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_mismatch <= 1'b1;
            if (r_retry < RETRY_W'(MAX_RETRY)) begin
              r_retry <= r_retry + RETRY_W'(1);
              r_j     <= w_j;
              r_k     <= w_k;
              r_state <= APPLY;
            end else begin
              r_fail  <= 1'b1;
              r_state <= FAIL;
            end
          end
        end

        FAIL: begin
          if (clr) begin
            r_fail  <= 1'b0;
            r_state <= IDLE;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready = (r_state == IDLE);
  assign j        = r_j;
  assign k        = r_k;
  assign done     = r_done;
  assign mismatch = r_mismatch;
  assign err_bits = r_err_bits;
  assign fail     = r_fail;

endmodule
